// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a synchronous word RAM, big-endian lanes.
// Define MAU_BYTE_ENABLE_EN to write sub-words with byte enables instead of read-modify-write.
module mem_access_unit #(
   parameter int ADDR_WORDS_LOG2 = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                address,
   input  logic [1:0]                 write,
   input  logic [31:0]                wdata,
   output logic [31:0]                rdata,
   output logic                       done,
   output logic                       error,
   output logic [ADDR_WORDS_LOG2-1:0] ram_addr,
   output logic [31:0]                ram_wdata,
   output logic                       ram_we,
`ifdef MAU_BYTE_ENABLE_EN
   output logic [3:0]                 ram_be,
`endif
   input  logic [31:0]                ram_rdata
);

   localparam int RANGE_SHIFT = ADDR_WORDS_LOG2 + 2;

   typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE, ERR} state_t;

   state_t                     state_r;
   state_t                     state_s;
   logic [ADDR_WORDS_LOG2-1:0] addr_r;
   logic [31:0]                data_r;
   logic [31:0]                rdata_r;
   logic                       done_r;
   logic                       error_r;
   logic                       we_r;
   logic                       oor_r;
   logic                       oor_s;
   logic                       misal_s;
   logic                       legal_s;
`ifdef MAU_BYTE_ENABLE_EN
   logic [3:0]                 be_r;
`else
   logic [1:0]                 size_r;
   logic [1:0]                 off_r;
`endif

   // Lane enables, bit 3 is byte offset 0 (bits 31:24).
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         2'b01:   m = 4'b1000 >> off;
         2'b10:   m = 4'b1100 >> off;
         2'b11:   m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [1:0] off,
                                             input logic [31:0] data);
      logic [31:0] d;
      case (size)
         2'b01:   d = {24'd0, data[7:0]} << {(2'd3 - off), 3'b000};
         2'b10:   d = {16'd0, data[15:0]} << {(2'd2 - off), 3'b000};
         2'b11:   d = data;
         default: d = 32'd0;
      endcase
      return d;
   endfunction

`ifndef MAU_BYTE_ENABLE_EN
   function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [3:0] m,
                                               input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = m[i] ? d[8*i +: 8] : old[8*i +: 8];
      end
      return r;
   endfunction
`endif

   // Request legality checks.
   always_comb begin
      oor_s   = (address >> RANGE_SHIFT) != 32'd0;
      misal_s = ((write == 2'b10) && address[0]) ||
                ((write == 2'b11) && (address[1:0] != 2'b00));
      legal_s = !oor_s && !misal_s;
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (write == 2'b00) begin
               state_s = IDLE;
            end else if (!legal_s) begin
               state_s = ERR;
            end else if (write == 2'b11) begin
               state_s = WR;
            end else begin
`ifdef MAU_BYTE_ENABLE_EN
               state_s = WR;
`else
               state_s = RD;
`endif
            end
         end
         RD:    state_s = MERGE;
         MERGE: state_s = WR;
         WR:    state_s = DONE;
         DONE, ERR: begin
            if (write == 2'b00) begin
               state_s = IDLE;
            end else begin
               state_s = state_r;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // RAM address: live from the core while idle so reads see one-cycle RAM latency.
   always_comb begin
      if (state_r == IDLE) begin
         ram_addr = address[ADDR_WORDS_LOG2+1:2];
      end else begin
         ram_addr = addr_r;
      end
   end

   // State, captured request and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         addr_r  <= '0;
         data_r  <= 32'd0;
         rdata_r <= 32'd0;
         done_r  <= 1'b0;
         error_r <= 1'b0;
         we_r    <= 1'b0;
         oor_r   <= 1'b0;
`ifdef MAU_BYTE_ENABLE_EN
         be_r    <= 4'd0;
`else
         size_r  <= 2'd0;
         off_r   <= 2'd0;
`endif
      end else begin
         state_r <= state_s;
         done_r  <= (state_s == DONE) || (state_s == ERR);
         error_r <= (state_s == ERR);
         we_r    <= (state_s == WR);
         oor_r   <= (state_r == IDLE) ? oor_s : 1'b0;
         if (state_r == IDLE) begin
            rdata_r <= oor_r ? 32'd0 : ram_rdata;
         end else begin
            rdata_r <= rdata_r;
         end
         if ((state_r == IDLE) && (write != 2'b00) && legal_s) begin
            addr_r <= address[ADDR_WORDS_LOG2+1:2];
`ifdef MAU_BYTE_ENABLE_EN
            data_r <= lane_data(write, address[1:0], wdata);
            be_r   <= lane_mask(write, address[1:0]);
`else
            data_r <= wdata;
            size_r <= write;
            off_r  <= address[1:0];
`endif
         end else if (state_r == MERGE) begin
`ifndef MAU_BYTE_ENABLE_EN
            data_r <= merge_lanes(ram_rdata, lane_mask(size_r, off_r),
                                  lane_data(size_r, off_r, data_r));
`else
            data_r <= data_r;
`endif
         end else begin
            data_r <= data_r;
         end
      end
   end

   assign rdata     = rdata_r;
   assign done      = done_r;
   assign error     = error_r;
   assign ram_wdata = data_r;
   assign ram_we    = we_r;
`ifdef MAU_BYTE_ENABLE_EN
   assign ram_be    = be_r;
`endif

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_WORDS_LOG2, default 12, giving log2 of RAM depth in 32-bit words.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port address, input, 32: byte address from the core.
REQ-005 SHALL have port write, input, 2: store size. 00 none, 01 byte, 10 halfword, 11 word.
REQ-006 SHALL have port wdata, input, 32: store data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-007 SHALL have port rdata, output, 32: registered read word.
REQ-008 SHALL have port done, output, 1: store complete, level.
REQ-009 SHALL have port error, output, 1: store rejected, level.
REQ-010 SHALL have port ram_addr, output, ADDR_WORDS_LOG2: word index to the synchronous RAM.
REQ-011 SHALL have port ram_wdata, output, 32: RAM write word.
REQ-012 SHALL have port ram_we, output, 1: RAM write strobe.
REQ-013 SHALL have port ram_rdata, input, 32: RAM read word, valid 1 cycle after ram_addr.

Function
REQ-014 Lane mapping SHALL be big-endian: byte offset k occupies word bits [31-8k:24-8k].
REQ-015 The FSM SHALL have states IDLE, RD, MERGE, WR, DONE and ERR.
REQ-016 In IDLE, ram_addr SHALL be address[ADDR_WORDS_LOG2+1:2], and rdata SHALL load ram_rdata every cycle, giving 1-cycle read latency.
REQ-017 A read SHALL return 0 in rdata when address bits above ADDR_WORDS_LOG2+1 are nonzero.
REQ-018 In IDLE with write != 00, a request SHALL be illegal if any of these hold:
- halfword and address[0] = 1;
- word and address[1:0] != 00;
- address out of range.
REQ-019 An illegal request SHALL go IDLE -> ERR with no RAM write; ERR asserts error and done.
REQ-020 A legal word store SHALL go IDLE -> WR, capturing address and wdata on entry.
REQ-021 A legal byte or halfword store SHALL go IDLE -> RD -> MERGE -> WR (read-modify-write).
REQ-022 MERGE SHALL replace only the addressed lane(s) of ram_rdata with wdata and register the merged word.
REQ-023 WR SHALL assert ram_we for exactly 1 cycle with the captured ram_addr and ram_wdata, then go to DONE.
REQ-024 DONE and ERR SHALL hold done = 1 until write = 00, then return to IDLE.
- A request is never re-issued while write is held.
REQ-025 Latency SHALL be: word store, done high 2 cycles after acceptance; sub-word store, 4 cycles.
REQ-026 Changes to address, write or wdata after acceptance SHALL be ignored until IDLE.
REQ-027 rdata SHALL hold its value outside IDLE.
REQ-028 ram_we SHALL never be 1 outside WR.

Reset
REQ-029 While rst = 0, the block SHALL force: state IDLE, done = 0, error = 0, ram_we = 0, rdata = 0, and all captured registers = 0.
REQ-030 Reset asserted mid-store SHALL abort the store with no RAM write.
REQ-031 After reset, the block SHALL accept a new request in the first cycle following rst deassertion.

Configuration
REQ-032 The macro MAU_BYTE_ENABLE_EN SHALL select how sub-word stores are written.
REQ-033 With MAU_BYTE_ENABLE_EN defined:
- an output port ram_be, 4 bits, SHALL exist, bit 3 = byte offset 0;
- all legal stores SHALL go IDLE -> WR with ram_be marking the written lanes;
- RD and MERGE are unused, and every store completes in 2 cycles.
REQ-034 Without MAU_BYTE_ENABLE_EN:
- ram_be SHALL be absent;
- sub-word stores SHALL use read-modify-write per REQ-021.

Verification
REQ-035 Read latency: preload word 5 = 0x11223344; address = 0x14, write = 00 -> rdata = 0x11223344 on the next edge.
REQ-036 Byte store: word 5 = 0x11223344; address 0x16, write 01, wdata 0xAB -> RAM word 5 = 0x1122AB44; done after 4 cycles.
REQ-037 Word store and hold: address 0x20, write 11, wdata 0xDEADBEEF -> single ram_we pulse; done held until write = 00; no second write.
REQ-038 Misalignment: address 0x21, write 10 -> error = 1 and done = 1, ram_we stays 0, RAM unchanged; both clear in the cycle after write = 00.
REQ-039 Out of range: address 0x4000 with ADDR_WORDS_LOG2 = 12, write 11 -> error = 1 and no write; a read of 0x4000 returns 0.
REQ-040 Reset mid-store: rst = 0 during MERGE -> ram_we never pulses; outputs at reset values; a new store after release completes normally.
